quad_nco: RTL and testbench

Parametrised quadrature NCO, the successor to the single-output 8-bit NCO. It produces signed sine and cosine from one phase accumulator, using a quarter-wave LUT with symmetry folding. It adds run-time frequency load, phase offset, phase sync, clock enable and a sample-valid pipeline. Sits in the carrier-recovery path, driven by the Costas loop filter's frequency word and feeding the I/Q mixers.

---
 rtl/quad_nco.sv | 223 ++++++++++++++++++++++
 tb/tb_quad_nco.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/quad_nco.sv
// ---------------------------------------------------------------------------
// quad_nco -- parametrised quadrature numerically controlled oscillator
//
// One phase accumulator drives signed sine and cosine outputs through a
// quarter-wave magnitude ROM. Quadrant folding mirrors the ROM index and
// selects the output sign. The pipeline has four stages and always advances.
// A low clock enable inserts a bubble, which shows up as out_valid=0.
//
// Parameters:
//   PHASE_WIDTH    accumulator / frequency-word width P (must exceed L)
//   OUTPUT_WIDTH   signed output width O, amplitude 2^(O-1)-1
//   LUT_ADDR_WIDTH full-cycle phase resolution L (>= 3), ROM depth 2^(L-2)
//   BASE_PHASE     accumulator value after reset or phase_sync
//
// Ports:
//   clk          clock
//   reset        asynchronous active-high reset
//   en           clock enable; advances the accumulator, marks sample valid
//   inc_load     latch phi_inc_i into the increment register
//   phi_inc_i    frequency word, 2^P * f_out / f_clk
//   phase_off_i  phase offset added after the accumulator, sampled per cycle
//   phase_sync   return the accumulator to BASE_PHASE
//   sin_o/cos_o  signed sine / cosine, symmetric range +/-(2^(O-1)-1)
//   out_valid    sin_o/cos_o hold a new sample
//
// Optional feature (macro NCO_DITHER_EN):
//   A 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) advances on
//   every enabled cycle. Its low min(16,P-L) bits are added below the LUT
//   address to spread truncation spurs. Latency is unchanged. Without the
//   macro, the output follows plain phase truncation bit-exactly.
//
// The quarter-wave table holds round(A*sin(2*pi*(k+0.5)/2^L)). It is computed
// at elaboration, so no initialisation file is needed. The half-bin offset
// keeps truncation centred and makes the quadrant mirror exact.
// ---------------------------------------------------------------------------
module quad_nco #(
    parameter int                      PHASE_WIDTH    = 32,
    parameter int                      OUTPUT_WIDTH   = 8,
    parameter int                      LUT_ADDR_WIDTH = 10,
    parameter logic [PHASE_WIDTH-1:0]  BASE_PHASE     = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           inc_load,
    input  logic [PHASE_WIDTH-1:0]         phi_inc_i,
    input  logic [PHASE_WIDTH-1:0]         phase_off_i,
    input  logic                           phase_sync,
    output logic signed [OUTPUT_WIDTH-1:0] sin_o,
    output logic signed [OUTPUT_WIDTH-1:0] cos_o,
    output logic                           out_valid
);

    localparam int  P      = PHASE_WIDTH;
    localparam int  O      = OUTPUT_WIDTH;
    localparam int  L      = LUT_ADDR_WIDTH;
    localparam int  QDEPTH = 1 << (L - 2);
    localparam int  MAG_W  = O - 1;
    localparam int  AMP    = (1 << (O - 1)) - 1;
    localparam real PI     = 3.14159265358979323846;

    // Elaboration-time sine magnitude for quarter-wave entry k (Taylor series).
    function automatic int quarter_mag(input int k);
        real x;
        real term;
        real sum;
        x    = 2.0 * PI * (real'(k) + 0.5) / real'(1 << L);
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return $rtoi(real'(AMP) * sum + 0.5);
    endfunction

    logic [MAG_W-1:0] rom [QDEPTH];

    for (genvar k = 0; k < QDEPTH; k++) begin : g_rom
        localparam logic [MAG_W-1:0] ENTRY = MAG_W'(quarter_mag(k));
        assign rom[k] = ENTRY;
    end

    logic [P-1:0]     acc;
    logic [P-1:0]     inc_reg;
    logic [P-1:0]     dither;
    logic [P-1:0]     p1;
    logic             v1;
    logic [L-3:0]     s2_sin_idx;
    logic [L-3:0]     s2_cos_idx;
    logic             s2_sin_neg;
    logic             s2_cos_neg;
    logic             v2;
    logic [MAG_W-1:0] s3_sin_mag;
    logic [MAG_W-1:0] s3_cos_mag;
    logic             s3_sin_neg;
    logic             s3_cos_neg;
    logic             v3;

`ifdef NCO_DITHER_EN
    localparam int DITHER_W = ((P - L) < 16) ? (P - L) : 16;

    logic [15:0] lfsr;

    // Dither source: Fibonacci LFSR stepping only on enabled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else if (en) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign dither = P'(lfsr[DITHER_W-1:0]);
`else
    assign dither = '0;
`endif

    // Increment register plus accumulator. Sync beats enable. A newly loaded
    // increment first affects the accumulator on the following edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_reg <= '0;
            acc     <= BASE_PHASE;
        end else begin
            if (inc_load) begin
                inc_reg <= phi_inc_i;
            end
            if (phase_sync) begin
                acc <= BASE_PHASE;
            end else if (en) begin
                acc <= acc + inc_reg;
            end
        end
    end

    // Stage 1: offset phase. This uses the accumulator value before this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1 <= '0;
            v1 <= 1'b0;
        end else begin
            p1 <= acc + phase_off_i + dither;
            v1 <= en;
        end
    end

    // Only the truncated top L bits address the table.
    logic p1_unused_bits;
    assign p1_unused_bits = ^p1[P-L-1:0];

    logic [L-1:0] r_sin;
    logic [L-1:0] r_cos;
    logic [L-3:0] sin_idx;
    logic [L-3:0] cos_idx;

    // Quadrant folding. Cosine is sine advanced by a quarter turn. Quadrants
    // 1 and 3 read the table mirrored, and quadrants 2 and 3 are negative.
    always_comb begin
        r_sin   = p1[P-1 -: L];
        r_cos   = r_sin + L'(QDEPTH);
        sin_idx = r_sin[L-2] ? ~r_sin[L-3:0] : r_sin[L-3:0];
        cos_idx = r_cos[L-2] ? ~r_cos[L-3:0] : r_cos[L-3:0];
    end

    // Stage 2: register the folded indices and the sign bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_sin_idx <= '0;
            s2_cos_idx <= '0;
            s2_sin_neg <= 1'b0;
            s2_cos_neg <= 1'b0;
            v2         <= 1'b0;
        end else begin
            s2_sin_idx <= sin_idx;
            s2_cos_idx <= cos_idx;
            s2_sin_neg <= r_sin[L-1];
            s2_cos_neg <= r_cos[L-1];
            v2         <= v1;
        end
    end

    // Stage 3: two registered reads of the shared ROM. Signs travel along.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_sin_mag <= '0;
            s3_cos_mag <= '0;
            s3_sin_neg <= 1'b0;
            s3_cos_neg <= 1'b0;
            v3         <= 1'b0;
        end else begin
            s3_sin_mag <= rom[s2_sin_idx];
            s3_cos_mag <= rom[s2_cos_idx];
            s3_sin_neg <= s2_sin_neg;
            s3_cos_neg <= s2_cos_neg;
            v3         <= v2;
        end
    end

    logic [O-1:0] sin_ext;
    logic [O-1:0] cos_ext;

    always_comb begin
        sin_ext = {1'b0, s3_sin_mag};
        cos_ext = {1'b0, s3_cos_mag};
    end

    // Stage 4: apply the sign. Outputs hold through bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sin_o     <= '0;
            cos_o     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (v3) begin
                sin_o <= s3_sin_neg ? -sin_ext : sin_ext;
                cos_o <= s3_cos_neg ? -cos_ext : cos_ext;
            end
            out_valid <= v3;
        end
    end

endmodule

// File: tb/tb_quad_nco.sv
// ---------------------------------------------------------------------------
// tb_quad_nco -- self-checking bench for quad_nco (P=32, O=8, L=10, base 0)
//
// A sample-level reference model predicts sin_o/cos_o/out_valid from ideal
// trigonometry. It uses a three-entry latency queue, and the outputs are
// compared on every falling edge. Directed phases pin that model with
// hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_quad_nco;

    localparam int           P    = 32;
    localparam int           O    = 8;
    localparam int           L    = 10;
    localparam int           AMP  = 127;
    localparam real          PI   = 3.14159265358979323846;
    localparam logic [P-1:0] BASE = '0;

    logic                clk         = 1'b0;
    logic                reset       = 1'b1;
    logic                en          = 1'b0;
    logic                inc_load    = 1'b0;
    logic                phase_sync  = 1'b0;
    logic [P-1:0]        phi_inc_i   = '0;
    logic [P-1:0]        phase_off_i = '0;
    logic signed [O-1:0] sin_o;
    logic signed [O-1:0] cos_o;
    logic                out_valid;

    int checks   = 0;
    int failures = 0;

    quad_nco #(
        .PHASE_WIDTH    (P),
        .OUTPUT_WIDTH   (O),
        .LUT_ADDR_WIDTH (L),
        .BASE_PHASE     (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .inc_load    (inc_load),
        .phi_inc_i   (phi_inc_i),
        .phase_off_i (phase_off_i),
        .phase_sync  (phase_sync),
        .sin_o       (sin_o),
        .cos_o       (cos_o),
        .out_valid   (out_valid)
    );

    always #5 clk = ~clk;

    // Ideal quantised trigonometry on the truncated phase, with the half-bin centre.
    function automatic int amp_round(input real v);
        real a;
        int  m;
        a = (v < 0.0) ? -v : v;
        m = $rtoi(a * real'(AMP) + 0.5);
        return (v < 0.0) ? -m : m;
    endfunction

    function automatic real phase_angle(input logic [P-1:0] ph);
        int r;
        r = int'(ph >> (P - L));
        return 2.0 * PI * (real'(r) + 0.5) / real'(1 << L);
    endfunction

    typedef struct packed {
        logic         valid;
        logic [P-1:0] phase;
    } sample_t;

    sample_t      pipe_q[$];
    logic [P-1:0] m_acc;
    logic [P-1:0] m_inc;
    int           m_sin;
    int           m_cos;
    logic         m_valid;

    // Reference model: each edge takes one phase sample (acc + offset). The
    // sample appears on the outputs three edges later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_acc   = BASE;
            m_inc   = '0;
            m_sin   = 0;
            m_cos   = 0;
            m_valid = 1'b0;
            pipe_q.delete();
            for (int i = 0; i < 3; i++) pipe_q.push_back('0);
        end else begin
            sample_t head;
            sample_t fresh;
            head = pipe_q.pop_front();
            if (head.valid) begin
                m_sin   = amp_round($sin(phase_angle(head.phase)));
                m_cos   = amp_round($cos(phase_angle(head.phase)));
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            fresh.valid = en;
            fresh.phase = m_acc + phase_off_i;
            pipe_q.push_back(fresh);
            if (phase_sync) m_acc = BASE;
            else if (en)    m_acc = m_acc + m_inc;
            if (inc_load)   m_inc = phi_inc_i;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        checks++;
        if (int'(sin_o) != m_sin || int'(cos_o) != m_cos || out_valid !== m_valid) begin
            failures++;
            $display("[TB] FAIL model_cmp t=%0t: sin=%0d cos=%0d valid=%0b, expected sin=%0d cos=%0d valid=%0b",
                     $time, sin_o, cos_o, out_valid, m_sin, m_cos, m_valid);
        end
    end

    task automatic applyStimulus(input logic e, input logic ld, input logic [P-1:0] inc,
                                 input logic [P-1:0] off, input logic sy);
        en          = e;
        inc_load    = ld;
        phi_inc_i   = inc;
        phase_off_i = off;
        phase_sync  = sy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int es, input int ec, input logic ev);
        checks++;
        if (int'(sin_o) != es || int'(cos_o) != ec || out_valid !== ev) begin
            failures++;
            $display("[TB] FAIL %s: sin=%0d cos=%0d valid=%0b, expected sin=%0d cos=%0d valid=%0b",
                     name, sin_o, cos_o, out_valid, es, ec, ev);
        end
    endtask

    int a_sin [4] = '{0, 127, 0, -127};
    int a_cos [4] = '{127, 0, -127, 0};
    int b_cos [4] = '{0, -127, 0, 127};
    int c_sin [5] = '{0, 0, 127, 127, 0};
    int c_cos [5] = '{127, 127, 0, 0, -127};
    logic c_val [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int d_sin [5] = '{127, 0, 0, 0, 0};
    int d_cos [5] = '{0, -127, 127, -127, 127};

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset_state", 0, 0, 1'b0);
        reset = 1'b0;

        // Quarter-turn rotation.
        $display("[TB] quarter-turn rotation");
        applyStimulus(1'b0, 1'b1, 32'h4000_0000, 32'h0, 1'b0);
        for (int j = 1; j <= 8; j++) begin
            applyStimulus(1'b1, 1'b0, 32'h4000_0000, 32'h0, 1'b0);
            if (j < 4) checkOutput("fill_latency", 0, 0, 1'b0);
            else       checkOutput("quarter_rot", a_sin[(j-4)%4], a_cos[(j-4)%4], 1'b1);
        end

        // A quarter-turn phase offset: sine follows the previous cosine.
        $display("[TB] phase offset");
        for (int j = 1; j <= 8; j++) begin
            applyStimulus(1'b1, 1'b0, 32'h4000_0000, 32'h4000_0000, 1'b0);
            if (j >= 4) checkOutput("phase_off", a_cos[(j-4)%4], b_cos[(j-4)%4], 1'b1);
        end

        // Alternating enable: bubbles and held outputs.
        $display("[TB] enable toggling");
        for (int j = 1; j <= 9; j++) begin
            applyStimulus(logic'(j % 2), 1'b0, 32'h4000_0000, 32'h0, 1'b0);
            if (j >= 4 && j <= 8) checkOutput("en_toggle", c_sin[j-4], c_cos[j-4], c_val[j-4]);
        end

        // Increment change to a half turn mid-run.
        $display("[TB] increment change");
        for (int j = 1; j <= 8; j++) begin
            applyStimulus(1'b1, logic'(j == 1), 32'h8000_0000, 32'h0, 1'b0);
            if (j >= 4) checkOutput("inc_change", d_sin[j-4], d_cos[j-4], 1'b1);
        end

        // Phase sync plus a slow negative rotation that wraps through zero.
        $display("[TB] phase sync and wrap");
        for (int j = 1; j <= 8; j++) begin
            applyStimulus(1'b1, logic'(j == 1), 32'hFFFF_FFFF, 32'h0, logic'(j == 1));
            if (j >= 4) checkOutput("sync_wrap", 0, 127, 1'b1);
        end

        // Mixed traffic checked against the model only.
        $display("[TB] mixed traffic");
        applyStimulus(1'b1, 1'b1, 32'h0357_9BDF, 32'h0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            logic         e;
            logic         ld;
            logic         sy;
            logic [P-1:0] inc;
            logic [P-1:0] off;
            e   = ($urandom_range(0, 9) != 0);
            ld  = ($urandom_range(0, 49) == 0);
            sy  = ($urandom_range(0, 79) == 0);
            inc = $urandom;
            off = ($urandom_range(0, 3) == 0) ? P'($urandom) : 32'h0;
            applyStimulus(e, ld, inc, off, sy);
        end

        // Asynchronous reset mid-stream, then restart with a zero increment.
        $display("[TB] mid-stream reset");
        applyStimulus(1'b1, 1'b1, 32'h1234_5678, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h1234_5678, 32'h0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 0, 0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
            if (j < 4) checkOutput("restart_fill", 0, 0, 1'b0);
            else       checkOutput("restart_const", 0, 127, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
